// File: rtl/cci_mpf_req_idx_alloc.sv
// Shared free-list allocator for temporally unique request indices.
// Two round-robin allocation clients, two free ports, and sticky double-free detection.
module cci_mpf_req_idx_alloc #(
    parameter int unsigned MAX_ACTIVE_REQS     = 128,
    parameter int unsigned ALM_EMPTY_THRESHOLD = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    output logic                               rdy,
    input  logic [1:0]                         alloc_req,
    output logic [1:0]                         alloc_gnt,
    output logic [$clog2(MAX_ACTIVE_REQS)-1:0] alloc_idx,
    input  logic [1:0]                         free_en,
    input  logic [$clog2(MAX_ACTIVE_REQS)-1:0] free_idx0,
    input  logic [$clog2(MAX_ACTIVE_REQS)-1:0] free_idx1,
    output logic [$clog2(MAX_ACTIVE_REQS):0]   n_free,
    output logic                               alm_empty,
    output logic                               err_double_free
);

    localparam int unsigned IdxW = $clog2(MAX_ACTIVE_REQS);

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [IdxW:0]   cnt_t;
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                     state_q;
    idx_t                       init_cnt_q;
    idx_t                       head_q;
    idx_t                       tail_q;
    cnt_t                       n_free_q;
    cnt_t                       n_free_d;
    logic [MAX_ACTIVE_REQS-1:0] in_use_q;
    logic [MAX_ACTIVE_REQS-1:0] in_use_d;
    logic                       err_q;
    logic                       last_q;
    idx_t                       fifo_q [MAX_ACTIVE_REQS];

    logic grant;
    logic ok0;
    logic ok1;
    logic dbl_free;

    assign rdy             = (state_q == StRun);
    assign alloc_idx       = fifo_q[head_q];
    assign grant           = |alloc_gnt;
    assign n_free          = n_free_q;
    assign alm_empty       = (n_free_q <= cnt_t'(ALM_EMPTY_THRESHOLD));
    assign err_double_free = err_q;

    // A same-cycle duplicate on port 1 is rejected so an index is never pushed twice.
    assign ok0 = rdy && free_en[0] && in_use_q[free_idx0];
    assign ok1 = rdy && free_en[1] && in_use_q[free_idx1] && !(ok0 && (free_idx0 == free_idx1));
    assign dbl_free = rdy && ((free_en[0] && !ok0) || (free_en[1] && !ok1));

    // last_q holds the most recent winner; on contention the other client wins.
    always_comb begin
        alloc_gnt = 2'b00;
        if (rdy && (n_free_q != '0)) begin
            unique case (alloc_req)
                2'b01:   alloc_gnt = 2'b01;
                2'b10:   alloc_gnt = 2'b10;
                2'b11:   alloc_gnt = last_q ? 2'b01 : 2'b10;
                default: alloc_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        in_use_d = in_use_q;
        if (grant) in_use_d[alloc_idx] = 1'b1;
        if (ok0)   in_use_d[free_idx0] = 1'b0;
        if (ok1)   in_use_d[free_idx1] = 1'b0;
        n_free_d = n_free_q - cnt_t'(grant) + cnt_t'(ok0) + cnt_t'(ok1);
    end

    // Free-list storage has no reset so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            fifo_q[init_cnt_q] <= init_cnt_q;
        end else begin
            if (ok0) fifo_q[tail_q] <= free_idx0;
            if (ok1) fifo_q[tail_q + idx_t'(ok0)] <= free_idx1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            n_free_q   <= '0;
            in_use_q   <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + idx_t'(1);
                    if (init_cnt_q == idx_t'(MAX_ACTIVE_REQS - 1)) begin
                        state_q  <= StRun;
                        n_free_q <= cnt_t'(MAX_ACTIVE_REQS);
                    end
                end
                StRun: begin
                    if (grant) begin
                        head_q <= head_q + idx_t'(1);
                        last_q <= alloc_gnt[1];
                    end
                    tail_q   <= tail_q + idx_t'(ok0) + idx_t'(ok1);
                    n_free_q <= n_free_d;
                    in_use_q <= in_use_d;
                    if (dbl_free) err_q <= 1'b1;
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_cci_mpf_req_idx_alloc.sv
// Bench for cci_mpf_req_idx_alloc (8 entries, low-water 2) with a free-list model and
// an expected-grant scoreboard.
module tb_cci_mpf_req_idx_alloc;

    localparam int unsigned Max = 8;
    localparam int unsigned Thr = 2;

    logic       clk;
    logic       reset_n;
    logic       rdy;
    logic [1:0] alloc_req;
    logic [1:0] alloc_gnt;
    logic [2:0] alloc_idx;
    logic [1:0] free_en;
    logic [2:0] free_idx0;
    logic [2:0] free_idx1;
    logic [3:0] n_free;
    logic       alm_empty;
    logic       err_double_free;

    cci_mpf_req_idx_alloc #(
        .MAX_ACTIVE_REQS     (Max),
        .ALM_EMPTY_THRESHOLD (Thr)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rdy             (rdy),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_idx       (alloc_idx),
        .free_en         (free_en),
        .free_idx0       (free_idx0),
        .free_idx1       (free_idx1),
        .n_free          (n_free),
        .alm_empty       (alm_empty),
        .err_double_free (err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] gnt;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];
    int   mfree[$];
    bit   muse[Max];
    bit   merr;
    bit   mlast;
    int   n_checks;
    int   n_errors;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mfree.delete();
        for (int i = 0; i < int'(Max); i++) begin
            mfree.push_back(i);
            muse[i] = 1'b0;
        end
        merr  = 1'b0;
        mlast = 1'b1;
        sb.delete();
    endtask

    // Hold reset 2 cycles with both clients requesting, then watch INIT.
    task automatic reset_seq();
        reset_n   = 1'b0;
        alloc_req = 2'b11;
        free_en   = 2'b00;
        free_idx0 = '0;
        free_idx1 = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("rst_rdy", int'(rdy), 0);
        check_val("rst_gnt", int'(alloc_gnt), 0);
        check_val("rst_n_free", int'(n_free), 0);
        check_val("rst_alm_empty", int'(alm_empty), 1);
        check_val("rst_err", int'(err_double_free), 0);
        reset_n = 1'b1;
        for (int i = 0; i < int'(Max); i++) begin
            @(negedge clk);
            check_val("init_rdy", int'(rdy), 0);
            check_val("init_gnt", int'(alloc_gnt), 0);
            @(posedge clk);
            #1;
        end
        alloc_req = 2'b00;
        #3;
        check_val("ready_rdy", int'(rdy), 1);
        check_val("ready_n_free", int'(n_free), int'(Max));
        check_val("ready_alm_empty", int'(alm_empty), 0);
        model_reset();
    endtask

    // One clock: drive, predict, compare mid-cycle, then advance the model.
    task automatic run_cycle(input logic [1:0] req, input logic [1:0] fen, input int i0,
                             input int i1);
        exp_t e;
        exp_t got;
        bit   a0;
        bit   a1;
        int   n;
        alloc_req = req;
        free_en   = fen;
        free_idx0 = 3'(i0);
        free_idx1 = 3'(i1);
        n     = mfree.size();
        e.gnt = 2'b00;
        e.idx = 3'd0;
        if (n > 0) begin
            case (req)
                2'b01:   e.gnt = 2'b01;
                2'b10:   e.gnt = 2'b10;
                2'b11:   e.gnt = mlast ? 2'b01 : 2'b10;
                default: e.gnt = 2'b00;
            endcase
        end
        if (e.gnt != 2'b00) e.idx = 3'(mfree[0]);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check_val("gnt", int'(alloc_gnt), int'(got.gnt));
        if (got.gnt != 2'b00) check_val("idx", int'(alloc_idx), int'(got.idx));
        check_val("n_free", int'(n_free), n);
        check_val("alm_empty", int'(alm_empty), int'(n <= int'(Thr)));
        check_val("err", int'(err_double_free), int'(merr));
        a0 = fen[0] && muse[i0];
        a1 = fen[1] && muse[i1] && !(a0 && (i0 == i1));
        if ((fen[0] && !a0) || (fen[1] && !a1)) merr = 1'b1;
        if (got.gnt != 2'b00) begin
            void'(mfree.pop_front());
            muse[got.idx] = 1'b1;
            mlast         = got.gnt[1];
        end
        if (a0) begin
            mfree.push_back(i0);
            muse[i0] = 1'b0;
        end
        if (a1) begin
            mfree.push_back(i1);
            muse[i1] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Round-robin from a fresh pool: 01,10,01,10 with idx 0..3.
        reset_seq();
        repeat (4) run_cycle(2'b11, 2'b00, 0, 0);

        // Mid-operation reset, then drain past empty.
        reset_seq();
        repeat (9) run_cycle(2'b01, 2'b00, 0, 0);

        // Dual free of 5 and 2, reused in that order.
        run_cycle(2'b00, 2'b11, 5, 2);
        run_cycle(2'b01, 2'b00, 0, 0);
        run_cycle(2'b01, 2'b00, 0, 0);

        // Double free of 3 across two cycles; flag is sticky, count moves once.
        run_cycle(2'b00, 2'b01, 3, 0);
        run_cycle(2'b00, 2'b01, 3, 0);
        run_cycle(2'b00, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b00, 0, 0);
        check_val("sticky_err", int'(err_double_free), 1);
        check_val("single_inc", int'(n_free), 1);

        // Same-cycle double free of 3.
        reset_seq();
        repeat (8) run_cycle(2'b01, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b11, 3, 3);
        check_val("same_cycle_err", int'(err_double_free), 1);
        check_val("same_cycle_inc", int'(n_free), 1);

        // Empty pool: free and request together, grant follows next cycle.
        run_cycle(2'b01, 2'b00, 0, 0);
        run_cycle(2'b01, 2'b01, 4, 0);
        run_cycle(2'b01, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
